// File: rtl/control_sequencer_if.sv
// Handshake bundle between fetch/issue, the control sequencer and the execute-stage control register.
// The master side issues instructions and consumes control beats; the slave side is the sequencer.
interface control_sequencer_if #(
    parameter int LANES = 4
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [4:0]        opcode;
    logic [2:0]        funct;
    logic              vec;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       ctrl;
    logic [LANE_W-1:0] lane;
    logic              last;
    logic              illegal;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output opcode, funct, vec, in_valid, out_ready,
        input  in_ready, ctrl, lane, last, illegal, out_valid
    );

    modport slave (
        input  opcode, funct, vec, in_valid, out_ready,
        output in_ready, ctrl, lane, last, illegal, out_valid
    );
endinterface

// File: rtl/control_sequencer.sv
// Registered decoder that turns {opcode, funct} into control-word beats, one per lane in vector
// mode, with an idle gap after every MUL beat while the multiplier is busy.
module control_sequencer #(
    parameter int LANES      = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    control_sequencer_if.slave   seqBus
);
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WAIT_LEN = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
    localparam int CNT_W    = (WAIT_LEN > 0) ? $clog2(WAIT_LEN + 1) : 1;
    localparam bit MUL_WAITS = (MUL_CYCLES > 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_LEN);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            r_state;
    logic [15:0]       r_ctrl;
    logic [LANE_W-1:0] r_lane;
    logic              r_last;
    logic              r_illegal;
    logic              r_valid;
    logic              r_mul;
    logic [CNT_W-1:0]  r_waitCnt;

    logic [15:0]       w_baseCtrl;
    logic              w_legal;
    logic              w_isMul;
    logic [15:0]       w_newCtrl;
    logic              w_newLast;
    logic              w_needWait;
    logic              w_inReady;
    logic              w_accept;
    logic [LANE_W-1:0] w_nextLane;
    logic              w_nextLast;

    always_comb begin
        w_baseCtrl = 16'h0000;
        w_legal    = 1'b1;
        case ({seqBus.opcode, seqBus.funct})
            8'b00000_000: w_baseCtrl = 16'h2400;
            8'b01000_000: w_baseCtrl = 16'h2408;
            8'b00000_001: w_baseCtrl = 16'h2420;
            8'b01001_001: w_baseCtrl = 16'h2428;
            8'b00000_010: w_baseCtrl = 16'h2440;
            8'b00000_100: w_baseCtrl = 16'h2480;
            8'b00000_101: w_baseCtrl = 16'h24A0;
            8'b00000_110: w_baseCtrl = 16'h24C0;
            default:      w_legal    = 1'b0;
        endcase
    end

    // Illegal instructions always collapse to a single zero beat regardless of vec.
    assign w_isMul   = ({seqBus.opcode, seqBus.funct} == 8'b00000_010);
    assign w_newCtrl = !w_legal   ? 16'h0000 :
                       seqBus.vec ? {w_baseCtrl[15:10], 2'b01, w_baseCtrl[7:0]} :
                                    w_baseCtrl;
    assign w_newLast = !(w_legal && seqBus.vec) || (LANES == 1);

    assign w_needWait = r_mul && MUL_WAITS;
    assign w_inReady  = (r_state == IDLE) ||
                        ((r_state == ISSUE) && seqBus.out_ready && r_last && !w_needWait);
    assign w_accept   = seqBus.in_valid && w_inReady;
    assign w_nextLane = r_lane + LANE_W'(1);
    assign w_nextLast = (w_nextLane == LAST_LANE);

    // Sequencer FSM; an accept can only happen from IDLE or on the final non-MUL beat,
    // so it takes priority over the per-state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ctrl    <= 16'h0000;
            r_lane    <= '0;
            r_last    <= 1'b0;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
            r_mul     <= 1'b0;
            r_waitCnt <= '0;
        end else if (w_accept) begin
            r_state   <= ISSUE;
            r_ctrl    <= w_newCtrl;
            r_lane    <= '0;
            r_last    <= w_newLast;
            r_illegal <= !w_legal;
            r_valid   <= 1'b1;
            r_mul     <= w_legal && w_isMul;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                end
                ISSUE: begin
                    if (seqBus.out_ready) begin
                        if (w_needWait) begin
                            r_state   <= WAIT;
                            r_valid   <= 1'b0;
                            r_waitCnt <= WAIT_INIT;
                        end else if (!r_last) begin
                            r_lane <= w_nextLane;
                            r_last <= w_nextLast;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (r_waitCnt == '0) begin
                        if (r_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= ISSUE;
                            r_valid <= 1'b1;
                            r_lane  <= w_nextLane;
                            r_last  <= w_nextLast;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign seqBus.in_ready  = w_inReady;
    assign seqBus.ctrl      = r_ctrl;
    assign seqBus.lane      = r_lane;
    assign seqBus.last      = r_last;
    assign seqBus.illegal   = r_illegal;
    assign seqBus.out_valid = r_valid;
endmodule
